// File: rtl/battleship_board_renderer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : battleship_board_renderer
// Purpose  : Two-stage pixel renderer for the battleship VGA path. It draws
//            NUM_BOARDS square boards of BOARD_N x BOARD_N cells side by side,
//            with black dividers between them. Cell states are fetched from an
//            external synchronous board RAM. A placement/aim cursor is overlaid
//            on the boards, and the syncs are delayed to match the two-strobe
//            pipeline latency.
// Ports    : clk, rst_n (async, active low), pix_en (pixel strobe)
//            x, y, de, hsync, vsync            - timing controller inputs
//            view_swap, own_board              - board placement / water shade
//            cur_board, cur_row, cur_col,
//            cur_len                           - cursor (cur_len = 0 hides it)
//            rd_board, rd_row, rd_col, rd_data - board RAM read port
//            r, g, b, hsync_o, vsync_o, de_o   - DAC side outputs
// Options  : `define CURSOR_BLINK_EN makes the cursor blink. It toggles every
//            BLINK_FRAMES vsync falls. When undefined, the cursor is solid.
// Revision : 1.0 - initial release
// ============================================================================
module battleship_board_renderer #(
    parameter int BOARD_N      = 5,
    parameter int NUM_BOARDS   = 2,
    parameter int CELL_PX      = 58,
    parameter int FRAME_PX     = 4,
    parameter int LINE_PX      = 2,
    parameter int BLINK_FRAMES = 16,
    parameter int XY_W         = 10,
    localparam int c_BW = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1,
    localparam int c_CW = (BOARD_N > 1) ? $clog2(BOARD_N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pix_en,
    input  logic [XY_W-1:0] x,
    input  logic [XY_W-1:0] y,
    input  logic            de,
    input  logic            hsync,
    input  logic            vsync,
    input  logic            view_swap,
    input  logic [c_BW-1:0] own_board,
    input  logic [c_BW-1:0] cur_board,
    input  logic [c_CW-1:0] cur_row,
    input  logic [c_CW-1:0] cur_col,
    input  logic [2:0]      cur_len,
    output logic [c_BW-1:0] rd_board,
    output logic [c_CW-1:0] rd_row,
    output logic [c_CW-1:0] rd_col,
    input  logic [1:0]      rd_data,
    output logic [7:0]      r,
    output logic [7:0]      g,
    output logic [7:0]      b,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic            de_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_PITCH = CELL_PX + FRAME_PX;
    // Cursor compare width: one bit wider than col/len so col+len never wraps
    localparam int c_SW    = ((c_CW > 3) ? c_CW : 3) + 1;

    localparam logic [XY_W-1:0] c_OFF_ONE    = XY_W'(1);
    localparam logic [XY_W-1:0] c_PITCH_LAST = XY_W'(c_PITCH - 1);
    localparam logic [XY_W-1:0] c_LINE_LAST  = XY_W'(LINE_PX - 1);
    localparam logic [XY_W-1:0] c_FRAME      = XY_W'(FRAME_PX);
    localparam logic [XY_W-1:0] c_CELL       = XY_W'(CELL_PX);

    // Column/row counters hold 0..BOARD_N; BOARD_N means "divider" for the
    // column counter and "below the boards" for the row counter.
    localparam logic [c_CW:0] c_CNT_ONE  = (c_CW + 1)'(1);
    localparam logic [c_CW:0] c_COL_LAST = (c_CW + 1)'(BOARD_N - 1);
    localparam logic [c_CW:0] c_CNT_END  = (c_CW + 1)'(BOARD_N);

    // Slot counter holds 0..NUM_BOARDS; NUM_BOARDS means "right of all slots".
    localparam logic [c_BW:0]   c_SLOT_ONE   = (c_BW + 1)'(1);
    localparam logic [c_BW:0]   c_SLOT_LAST  = (c_BW + 1)'(NUM_BOARDS - 1);
    localparam logic [c_BW:0]   c_SLOT_OFF   = (c_BW + 1)'(NUM_BOARDS);
    localparam logic [c_BW-1:0] c_BOARD_LAST = c_BW'(NUM_BOARDS - 1);

    localparam logic [23:0] c_BLACK      = 24'h000000;
    localparam logic [23:0] c_WHITE      = 24'hFFFFFF;
    localparam logic [23:0] c_CURSOR     = 24'hFF8C00;
    localparam logic [23:0] c_OWN_WATER  = 24'h0000FF;
    localparam logic [23:0] c_FOE_WATER  = 24'h66CCFF;
    localparam logic [23:0] c_SHIP       = 24'h00FF00;
    localparam logic [23:0] c_MISS       = 24'hFF0000;
    localparam logic [23:0] c_HIT        = 24'hFFFF00;

    // ------------------------------------------------------------------------
    // Horizontal position counters. The w_* values describe the current pixel.
    // At x == 0 they are forced to the origin, so the stored state only needs
    // to be valid for the following strobes of the same line.
    // ------------------------------------------------------------------------
    logic [XY_W-1:0] r_ox, w_ox, w_ox_nxt;
    logic [c_CW:0]   r_col, w_col, w_col_nxt;
    logic [c_BW:0]   r_slot, w_slot, w_slot_nxt;

    always_comb begin
        w_ox   = r_ox;
        w_col  = r_col;
        w_slot = r_slot;
        if (x == '0) begin
            w_ox   = '0;
            w_col  = '0;
            w_slot = '0;
        end
    end

    always_comb begin
        w_ox_nxt   = w_ox + c_OFF_ONE;
        w_col_nxt  = w_col;
        w_slot_nxt = w_slot;
        if (w_slot == c_SLOT_OFF) begin
            w_ox_nxt = w_ox;                       // saturated past the last slot
        end else if (w_col == c_CNT_END) begin
            if (w_ox == c_LINE_LAST) begin         // end of divider
                w_ox_nxt   = '0;
                w_col_nxt  = '0;
                w_slot_nxt = w_slot + c_SLOT_ONE;
            end
        end else if (w_ox == c_PITCH_LAST) begin   // end of a cell
            w_ox_nxt = '0;
            if (w_col != c_COL_LAST) begin
                w_col_nxt = w_col + c_CNT_ONE;
            end else if (w_slot == c_SLOT_LAST) begin
                w_slot_nxt = c_SLOT_OFF;
            end else if (LINE_PX == 0) begin
                w_col_nxt  = '0;
                w_slot_nxt = w_slot + c_SLOT_ONE;
            end else begin
                w_col_nxt = c_CNT_END;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Vertical position counters. They are stepped once per line, on the
    // x == 0 strobe. The stored value then describes the line being drawn.
    // ------------------------------------------------------------------------
    logic [XY_W-1:0] r_oy, w_oy, w_oy_adv;
    logic [c_CW:0]   r_row, w_row, w_row_adv;

    always_comb begin
        w_oy_adv  = r_oy + c_OFF_ONE;
        w_row_adv = r_row;
        if (r_row == c_CNT_END) begin
            w_oy_adv = r_oy;                       // saturated below the boards
        end else if (r_oy == c_PITCH_LAST) begin
            w_oy_adv  = '0;
            w_row_adv = r_row + c_CNT_ONE;
        end
        w_oy  = r_oy;
        w_row = r_row;
        if (x == '0) begin
            if (y == '0) begin
                w_oy  = '0;
                w_row = '0;
            end else begin
                w_oy  = w_oy_adv;
                w_row = w_row_adv;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ox   <= '0;
            r_col  <= '0;
            r_slot <= '0;
            r_oy   <= '0;
            r_row  <= '0;
        end else if (pix_en) begin
            r_ox   <= w_ox_nxt;
            r_col  <= w_col_nxt;
            r_slot <= w_slot_nxt;
            if (x == '0) begin
                r_oy  <= w_oy;
                r_row <= w_row;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: classify the pixel, issue the RAM read, evaluate the cursor
    // ------------------------------------------------------------------------
    logic            w_on_cell;
    logic            w_inside;
    logic            w_divider;
    logic [c_BW-1:0] w_board;
    logic [c_SW-1:0] w_col_e;
    logic [c_SW-1:0] w_cur_lo;
    logic [c_SW-1:0] w_cur_hi;
    logic            w_cur_hit;

    assign w_board   = view_swap ? (c_BOARD_LAST - w_slot[c_BW-1:0]) : w_slot[c_BW-1:0];
    assign w_on_cell = (w_slot != c_SLOT_OFF) && (w_col != c_CNT_END) && (w_row != c_CNT_END);
    assign w_inside  = w_on_cell && (w_ox >= c_FRAME) && (w_ox < c_CELL)
                                 && (w_oy >= c_FRAME) && (w_oy < c_CELL);
    // The divider runs the full screen height.
    assign w_divider = (w_slot != c_SLOT_OFF) && (w_col == c_CNT_END);

    assign w_col_e   = c_SW'(w_col[c_CW-1:0]);
    assign w_cur_lo  = c_SW'(cur_col);
    assign w_cur_hi  = c_SW'(cur_col) + c_SW'(cur_len);
    assign w_cur_hit = w_on_cell && (w_board == cur_board)
                                 && (w_row[c_CW-1:0] == cur_row)
                                 && (w_col_e >= w_cur_lo) && (w_col_e < w_cur_hi);

    logic r_s1_inside, r_s1_div, r_s1_cur, r_s1_own, r_s1_de, r_s1_hs, r_s1_vs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_board    <= '0;
            rd_row      <= '0;
            rd_col      <= '0;
            r_s1_inside <= 1'b0;
            r_s1_div    <= 1'b0;
            r_s1_cur    <= 1'b0;
            r_s1_own    <= 1'b0;
            r_s1_de     <= 1'b0;
            r_s1_hs     <= 1'b1;
            r_s1_vs     <= 1'b1;
        end else if (pix_en) begin
            // Off-board pixels park the read address at cell 0 of board 0.
            rd_board    <= w_on_cell ? w_board : '0;
            rd_row      <= w_on_cell ? w_row[c_CW-1:0] : '0;
            rd_col      <= w_on_cell ? w_col[c_CW-1:0] : '0;
            r_s1_inside <= w_inside;
            r_s1_div    <= w_divider;
            r_s1_cur    <= w_cur_hit;
            r_s1_own    <= (w_board == own_board);
            r_s1_de     <= de;
            r_s1_hs     <= hsync;
            r_s1_vs     <= vsync;
        end
    end

    // ------------------------------------------------------------------------
    // Cursor blink phase
    // ------------------------------------------------------------------------
    logic w_blink_phase;

`ifdef CURSOR_BLINK_EN
    localparam int c_BLW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [c_BLW-1:0] c_BLINK_LAST = c_BLW'(BLINK_FRAMES - 1);
    localparam logic [c_BLW-1:0] c_BLINK_ONE  = c_BLW'(1);

    logic [c_BLW-1:0] r_blink_cnt;
    logic             r_blink_phase;
    logic             r_vsync_d;

    // Counts vsync falling edges on every clock, independent of pix_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
            r_vsync_d     <= 1'b1;
        end else begin
            r_vsync_d <= vsync;
            if (r_vsync_d && !vsync) begin
                if (r_blink_cnt == c_BLINK_LAST) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + c_BLINK_ONE;
                end
            end
        end
    end

    assign w_blink_phase = r_blink_phase;
`else
    // A solid cursor has no frame period to count.
    logic w_unused_blink;
    assign w_unused_blink = ^BLINK_FRAMES;
    assign w_blink_phase  = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Stage 2: colour from rd_data (which answers the stage-1 address)
    // ------------------------------------------------------------------------
    logic [23:0] w_rgb;

    always_comb begin
        w_rgb = c_WHITE;
        if (!r_s1_de) begin
            w_rgb = c_BLACK;
        end else if (r_s1_div) begin
            w_rgb = c_BLACK;
        end else if (r_s1_cur && w_blink_phase) begin
            w_rgb = c_CURSOR;
        end else if (r_s1_inside) begin
            case (rd_data)
                2'b00:   w_rgb = r_s1_own ? c_OWN_WATER : c_FOE_WATER;
                2'b01:   w_rgb = c_SHIP;
                2'b10:   w_rgb = c_MISS;
                default: w_rgb = c_HIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r       <= '0;
            g       <= '0;
            b       <= '0;
            de_o    <= 1'b0;
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
        end else if (pix_en) begin
            r       <= w_rgb[23:16];
            g       <= w_rgb[15:8];
            b       <= w_rgb[7:0];
            de_o    <= r_s1_de;
            hsync_o <= r_s1_hs;
            vsync_o <= r_s1_vs;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_battleship_board_renderer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_battleship_board_renderer
// Purpose  : Scoreboard bench for battleship_board_renderer (default params).
//            The stimulus queues the expected {rgb, de, hsync, vsync} for every
//            pixel strobe. The monitor pops one entry per strobe once the
//            two-strobe pipeline has filled. The bench also models the board
//            RAM, which answers one clock after the address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_battleship_board_renderer;

    localparam logic [23:0] BLACK  = 24'h000000;
    localparam logic [23:0] WHITE  = 24'hFFFFFF;
    localparam logic [23:0] ORANGE = 24'hFF8C00;
    localparam logic [23:0] DBLUE  = 24'h0000FF;
    localparam logic [23:0] LBLUE  = 24'h66CCFF;
    localparam logic [23:0] GREEN  = 24'h00FF00;
    localparam logic [23:0] RED    = 24'hFF0000;
    localparam logic [23:0] YELLOW = 24'hFFFF00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_en;
    logic [9:0] x, y;
    logic       de, hsync, vsync, view_swap;
    logic [0:0] own_board, cur_board;
    logic [2:0] cur_row, cur_col, cur_len;
    logic [0:0] rd_board;
    logic [2:0] rd_row, rd_col;
    logic [1:0] rd_data = 2'b00;
    logic [7:0] r, g, b;
    logic       hsync_o, vsync_o, de_o;

    battleship_board_renderer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pix_en   (pix_en),
        .x        (x),
        .y        (y),
        .de       (de),
        .hsync    (hsync),
        .vsync    (vsync),
        .view_swap(view_swap),
        .own_board(own_board),
        .cur_board(cur_board),
        .cur_row  (cur_row),
        .cur_col  (cur_col),
        .cur_len  (cur_len),
        .rd_board (rd_board),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .rd_data  (rd_data),
        .r        (r),
        .g        (g),
        .b        (b),
        .hsync_o  (hsync_o),
        .vsync_o  (vsync_o),
        .de_o     (de_o)
    );

    always #5 clk = ~clk;

    // Board RAM: index = board*25 + row*5 + col
    logic [1:0] ram [50];
    always @(posedge clk) rd_data <= ram[int'(rd_board) * 25 + int'(rd_row) * 5 + int'(rd_col)];

    typedef struct {
        bit          chk;
        logic [26:0] exp;
        string       name;
    } ent_t;

    ent_t        sb[$];
    logic [23:0] want [int];
    int          n_checks = 0;
    int          n_errors = 0;
    int          nstrobe  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: after strobe n (n >= 2), the outputs show pixel n-1.
    initial begin
        ent_t e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                nstrobe = 0;
            end else if (pix_en) begin
                nstrobe++;
                #1;
                if (nstrobe >= 2) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_underflow: got empty queue expected an entry");
                    end else begin
                        e = sb.pop_front();
                        if (e.chk) begin
                            n_checks++;
                            if ({r, g, b, de_o, hsync_o, vsync_o} !== e.exp) begin
                                n_errors++;
                                $display("FAIL %s: got rgb=%h de=%b hs=%b vs=%b expected rgb=%h de=%b hs=%b vs=%b",
                                         e.name, {r, g, b}, de_o, hsync_o, vsync_o,
                                         e.exp[26:3], e.exp[2], e.exp[1], e.exp[0]);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic strobe(input int xx, input int yy, input bit dd, input bit hh, input bit vv,
                          input bit chk, input logic [23:0] rgb, input string nm);
        ent_t e;
        @(negedge clk);
        x      = 10'(xx);
        y      = 10'(yy);
        de     = dd;
        hsync  = hh;
        vsync  = vv;
        pix_en = 1'b1;
        if (rst_n) begin
            e.chk  = chk;
            e.exp  = {rgb, dd, hh, vv};
            e.name = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic scan(input int yy, input int x0, input int x1);
        for (int xx = x0; xx <= x1; xx++) begin
            if (want.exists(xx))
                strobe(xx, yy, 1'b1, 1'b1, 1'b1, 1'b1, want[xx], $sformatf("y%0d_x%0d", yy, xx));
            else
                strobe(xx, yy, 1'b1, 1'b1, 1'b1, 1'b0, BLACK, "fill");
        end
    endtask

    // Only the x == 0 pixel of each line (always frame or off-board white)
    task automatic lines_x0(input int y0, input int y1);
        for (int yy = y0; yy <= y1; yy++)
            strobe(0, yy, 1'b1, 1'b1, 1'b1, 1'b1, WHITE, $sformatf("x0_y%0d", yy));
    endtask

    task automatic vpulses(input int n);
        for (int i = 0; i < n; i++) begin
            strobe(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, BLACK, "vpulse_lo");
            strobe(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, BLACK, "vpulse_hi");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; pix_en = 1'b0; x = 10'd10; y = 10'd10;
        de = 1'b1; hsync = 1'b1; vsync = 1'b1; view_swap = 1'b0;
        own_board = 1'b0; cur_board = 1'b0; cur_row = '0; cur_col = '0; cur_len = '0;
        for (int i = 0; i < 50; i++) ram[i] = 2'b00;
        ram[7]  = 2'b01;   // board0 (1,2) ship
        ram[20] = 2'b10;   // board0 (4,0) miss
        ram[30] = 2'b11;   // board1 (1,0) hit

        // Reset held with de=1 at (10,10)
        repeat (3) @(negedge clk);
        strobe(10, 10, 1'b1, 1'b1, 1'b1, 1'b0, BLACK, "in_rst");
        check("rst_rgb",   {8'h0, r, g, b}, 32'h0);
        check("rst_syncs", {29'h0, hsync_o, vsync_o, de_o}, 32'h6);
        check("rst_rd",    {25'h0, rd_board, rd_row, rd_col}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Some live pixels, then an asynchronous reset mid-cycle
        for (int xx = 0; xx <= 12; xx++)
            strobe(xx, 0, 1'b1, 1'b0, 1'b1, 1'b1, WHITE, $sformatf("pre_x%0d", xx));
        @(negedge clk);
        x = 10'd10; y = 10'd10;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rgb",   {8'h0, r, g, b}, 32'h0);
        check("async_rst_syncs", {29'h0, hsync_o, vsync_o, de_o}, 32'h6);
        sb.delete();
        strobe(10, 10, 1'b1, 1'b1, 1'b1, 1'b0, BLACK, "in_rst");
        strobe(11, 10, 1'b1, 1'b1, 1'b1, 1'b0, BLACK, "in_rst");
        check("hold_rst_rgb", {8'h0, r, g, b, de_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First strobe after reset still shows the reset pipeline contents
        strobe(0, 0, 1'b1, 1'b1, 1'b1, 1'b1, WHITE, "first_px");
        check("lat1_out", {7'h0, r, g, b, de_o}, 32'h0);

        lines_x0(1, 1);

        // Frame row: divider black, frames white
        want.delete();
        want[10] = WHITE; want[309] = WHITE; want[310] = BLACK;
        want[311] = BLACK; want[312] = WHITE; want[317] = WHITE;
        scan(2, 0, 320);
        lines_x0(3, 71);

        // Row 1 interior, normal order
        want.delete();
        want[0] = WHITE; want[10] = DBLUE; want[72] = DBLUE; want[127] = WHITE;
        want[128] = GREEN; want[134] = GREEN; want[181] = GREEN; want[182] = WHITE;
        want[309] = WHITE; want[310] = BLACK; want[311] = BLACK; want[312] = WHITE;
        want[317] = YELLOW; want[384] = LBLUE; want[621] = WHITE; want[622] = WHITE;
        want[639] = WHITE;
        scan(72, 0, 134);
        check("rd_addr_134", {25'h0, rd_board, rd_row, rd_col}, {25'h0, 1'b0, 3'd1, 3'd2});
        scan(72, 135, 639);

        // Swapped view
        view_swap = 1'b1;
        want.delete();
        want[10] = YELLOW; want[72] = LBLUE; want[134] = LBLUE;
        want[322] = DBLUE; want[384] = DBLUE; want[446] = GREEN;
        scan(73, 0, 446);
        check("rd_addr_swap", {25'h0, rd_board, rd_row, rd_col}, {25'h0, 1'b0, 3'd1, 3'd2});
        view_swap = 1'b0;
        lines_x0(74, 195);

        // Cursor at board0 row4 cols 3..6 (clipped at col 4)
        cur_board = 1'b0; cur_row = 3'd4; cur_col = 3'd3; cur_len = 3'd4;
        want.delete();
        want[196] = DBLUE; want[258] = DBLUE;
        scan(196, 0, 258);
        lines_x0(197, 257);
        want.delete();
        want[10] = RED; want[134] = DBLUE; want[196] = ORANGE; want[258] = ORANGE;
        want[310] = BLACK; want[322] = LBLUE;
        scan(258, 0, 322);

        // Blink: 16 vsync falls hide the cursor, 16 more show it again
        for (int rnd = 0; rnd < 2; rnd++) begin
            vpulses(16);
            lines_x0(0, 257);
            want.delete();
            want[10] = RED;
`ifdef CURSOR_BLINK_EN
            want[196] = (rnd == 0) ? DBLUE : ORANGE;
`else
            want[196] = ORANGE;
`endif
            scan(258, 0, 196);
        end

        strobe(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, BLACK, "flush");
        strobe(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, BLACK, "flush");
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
